// File: rtl/serial_pe_seq_if.sv
// Bus bundle for serial_pe_seq: host control, neuron/weight SRAM reads,
// PE ctl/valid stream and output SRAM writes.
// slave = the sequencer itself; master = whatever surrounds it (host, SRAMs, PE).
interface serial_pe_seq_if #(
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned NADDR_W = 10,
    parameter int unsigned WADDR_W = 16,
    parameter int unsigned OADDR_W = 10
) ();
    logic               start;
    logic [CNT_W-1:0]   cfg_num_in;
    logic [CNT_W-1:0]   cfg_num_out;
    logic               busy;
    logic               done;
    logic               nram_rd_en;
    logic [NADDR_W-1:0] nram_addr;
    logic               wram_rd_en;
    logic [WADDR_W-1:0] wram_addr;
    logic [1:0]         pe_ctl;
    logic               pe_vld_i;
    logic               pe_vld_o;
    logic [31:0]        pe_result;
    logic               oram_we;
    logic [OADDR_W-1:0] oram_addr;
    logic [31:0]        oram_wdata;

    modport slave (
        input  start, cfg_num_in, cfg_num_out, pe_vld_o, pe_result,
        output busy, done, nram_rd_en, nram_addr, wram_rd_en, wram_addr,
               pe_ctl, pe_vld_i, oram_we, oram_addr, oram_wdata
    );

    modport master (
        output start, cfg_num_in, cfg_num_out, pe_vld_o, pe_result,
        input  busy, done, nram_rd_en, nram_addr, wram_rd_en, wram_addr,
               pe_ctl, pe_vld_i, oram_we, oram_addr, oram_wdata
    );
endinterface

// File: rtl/serial_pe_seq.sv
// Sequencer for one serial MAC PE running a fully-connected layer:
// out[o] = sum_i neuron[i] * weight[o*N_IN + i].
// Issues one neuron/weight read pair per cycle, forwards first/last term flags to the PE
// one cycle later (aligned with SRAM read data) and writes each PE result to the output SRAM.
// rst_n asserts asynchronously; its release is expected to be synchronous to clk.
module serial_pe_seq #(
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned NADDR_W = 10,
    parameter int unsigned WADDR_W = 16,
    parameter int unsigned OADDR_W = 10
) (
    input logic              clk,
    input logic              rst_n,
    serial_pe_seq_if.slave   bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   n_in_q, n_out_q;
    logic [CNT_W-1:0]   i_q, o_q, wr_cnt_q;
    logic [WADDR_W-1:0] waddr_q;
    logic               pe_vld_q;
    logic [1:0]         pe_ctl_q;
    logic               oram_we_q;
    logic [OADDR_W-1:0] oram_addr_q;
    logic [31:0]        oram_wdata_q;

    logic start_ok, cfg_zero, issue, last_i, last_o, capture;

    // Decode of the current cycle's actions
    always_comb begin
        start_ok = (state_q == StIdle) && bus.start;
        cfg_zero = (bus.cfg_num_in == '0) || (bus.cfg_num_out == '0);
        issue    = (state_q == StRun);
        last_i   = (i_q == n_in_q - CNT_W'(1));
        last_o   = (o_q == n_out_q - CNT_W'(1));
        // PE results are only meaningful while a layer is in flight
        capture  = bus.pe_vld_o && ((state_q == StRun) || (state_q == StDrain));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_ok) state_d = cfg_zero ? StDone : StRun;
            StRun:   if (last_i && last_o) state_d = StDrain;
            // wr_cnt_q already counts the write currently on the bus
            StDrain: if (oram_we_q && (wr_cnt_q == n_out_q)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Latched configuration and loop/address counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_in_q   <= '0;
            n_out_q  <= '0;
            i_q      <= '0;
            o_q      <= '0;
            waddr_q  <= '0;
            wr_cnt_q <= '0;
        end else if (start_ok) begin
            n_in_q   <= bus.cfg_num_in;
            n_out_q  <= bus.cfg_num_out;
            i_q      <= '0;
            o_q      <= '0;
            waddr_q  <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (issue) begin
                waddr_q <= waddr_q + WADDR_W'(1);
                if (last_i) begin
                    i_q <= '0;
                    o_q <= o_q + CNT_W'(1);
                end else begin
                    i_q <= i_q + CNT_W'(1);
                end
            end
            if (capture) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        end
    end

    // PE stage: delay valid/ctl one cycle so they meet the SRAM read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_vld_q <= 1'b0;
            pe_ctl_q <= 2'b00;
        end else begin
            pe_vld_q <= issue;
            pe_ctl_q <= issue ? {last_i, (i_q == '0)} : 2'b00;
        end
    end

    // Writeback register for the output SRAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oram_we_q    <= 1'b0;
            oram_addr_q  <= '0;
            oram_wdata_q <= '0;
        end else begin
            oram_we_q <= capture;
            if (capture) begin
                oram_addr_q  <= OADDR_W'(wr_cnt_q);
                oram_wdata_q <= bus.pe_result;
            end
        end
    end

    // Output drive
    always_comb begin
        bus.busy       = (state_q != StIdle);
        bus.done       = (state_q == StDone);
        bus.nram_rd_en = issue;
        bus.nram_addr  = NADDR_W'(i_q);
        bus.wram_rd_en = issue;
        bus.wram_addr  = waddr_q;
        bus.pe_ctl     = pe_ctl_q;
        bus.pe_vld_i   = pe_vld_q;
        bus.oram_we    = oram_we_q;
        bus.oram_addr  = oram_addr_q;
        bus.oram_wdata = oram_wdata_q;
    end

endmodule

// File: tb/tb_serial_pe_seq.sv
// Bench for serial_pe_seq: behavioural neuron/weight SRAMs (1-cycle read) and a serial MAC PE
// around the DUT; directed layer vectors from a table plus hand-written corner sequences.
// Cycle numbering: cycle 0 is the cycle with start high; events are sampled at negedge.
module tb_serial_pe_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_pe_seq_if bus ();

    serial_pe_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- SRAM and PE models ----------------
    logic signed [15:0] nmem [0:15];
    logic signed [15:0] wmem [0:15];
    logic signed [15:0] nrd, wrd;
    logic signed [31:0] acc_q, res_q, prod, acc_n;
    logic               vo_q;
    logic               inject = 1'b0;

    always @(posedge clk) begin
        if (bus.nram_rd_en) nrd <= nmem[bus.nram_addr[3:0]];
        if (bus.wram_rd_en) wrd <= wmem[bus.wram_addr[3:0]];
    end

    always_comb begin
        prod  = nrd * wrd;
        acc_n = bus.pe_ctl[0] ? prod : acc_q + prod;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            res_q <= '0;
            vo_q  <= 1'b0;
        end else begin
            vo_q <= 1'b0;
            if (bus.pe_vld_i) begin
                acc_q <= acc_n;
                if (bus.pe_ctl[1]) begin
                    vo_q  <= 1'b1;
                    res_q <= acc_n;
                end
            end
        end
    end

    assign bus.pe_vld_o  = vo_q | inject;
    assign bus.pe_result = res_q;

    // ---------------- checking helpers ----------------
    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_int({tag, "_busy_done"}, int'({bus.busy, bus.done}), 0);
        check_int({tag, "_strobes"},
                  int'({bus.nram_rd_en, bus.wram_rd_en, bus.pe_vld_i, bus.oram_we}), 0);
        check_int({tag, "_rd_addr"}, int'({bus.nram_addr, bus.wram_addr}), 0);
        check_int({tag, "_pe_ctl"}, int'(bus.pe_ctl), 0);
        check_int({tag, "_oram_bus"}, int'(bus.oram_wdata) | int'(bus.oram_addr), 0);
    endtask

    // ---------------- vector table ----------------
    // Packed members are listed msb-first: element [0] is the rightmost field.
    typedef struct {
        int                n_in;
        int                n_out;
        logic [3:0][15:0]  nrn;
        logic [7:0][15:0]  wgt;
        logic [3:0][31:0]  exp_o;
    } vec_t;

    vec_t vecs [4];

    // Run one layer and compare everything observable against the vector's expectations.
    // disturb: pulse start and change cfg mid-run, and pulse start again during DONE.
    task automatic run_vec(input int id, input vec_t v, input bit disturb);
        int L;
        int n_rd, n_vi, n_c3, n_busy, n_done, done_cyc, n_wr, addr_err;
        logic [31:0] got [4];
        int got_cyc [4];
        string tag;
        L = v.n_in * v.n_out;
        tag = $sformatf("v%0d%s", id, disturb ? "d" : "");
        n_rd = 0; n_vi = 0; n_c3 = 0; n_busy = 0; n_done = 0; done_cyc = -1;
        n_wr = 0; addr_err = 0;
        for (int k = 0; k < 4; k++) begin
            got[k] = '0;
            got_cyc[k] = -1;
        end
        for (int k = 0; k < 16; k++) begin
            nmem[k] = (k < 4) ? v.nrn[k] : 16'sd0;
            wmem[k] = (k < 8) ? v.wgt[k] : 16'sd0;
        end

        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.cfg_num_in  = 10'(v.n_in);
        bus.cfg_num_out = 10'(v.n_out);
        @(posedge clk);
        #1;
        bus.start = 1'b0;

        for (int rel = 1; rel <= L + 10; rel++) begin
            @(negedge clk);
            if (bus.busy) n_busy++;
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = rel;
            end
            if (bus.nram_rd_en || bus.wram_rd_en) begin
                if (!(bus.nram_rd_en && bus.wram_rd_en)) addr_err++;
                if (int'(bus.nram_addr) != n_rd % v.n_in) addr_err++;
                if (int'(bus.wram_addr) != n_rd) addr_err++;
                if (rel != n_rd + 1) addr_err++;
                n_rd++;
            end
            if (bus.pe_vld_i) begin
                n_vi++;
                if (bus.pe_ctl == 2'b11) n_c3++;
            end
            if (bus.oram_we) begin
                if (n_wr < 4) begin
                    got[n_wr]     = bus.oram_wdata;
                    got_cyc[n_wr] = rel;
                    if (int'(bus.oram_addr) != n_wr) addr_err++;
                end
                n_wr++;
            end
            if (disturb) begin
                if (rel == 3) begin
                    bus.start       = 1'b1;
                    bus.cfg_num_in  = 10'd1;
                    bus.cfg_num_out = 10'd1;
                end
                if (rel == 4) bus.start = 1'b0;
                if (rel == L + 4) bus.start = 1'b1;
                if (rel == L + 5) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;

        for (int o = 0; o < v.n_out; o++) begin
            check_int($sformatf("%s_oram%0d_data", tag, o), int'(got[o]), int'(v.exp_o[o]));
            // last term of output o issues in cycle (o+1)*N_IN; write lands 3 cycles later
            check_int($sformatf("%s_oram%0d_cycle", tag, o), got_cyc[o], (o + 1) * v.n_in + 3);
        end
        check_int({tag, "_writes"}, n_wr, v.n_out);
        check_int({tag, "_reads"}, n_rd, L);
        check_int({tag, "_addr_errs"}, addr_err, 0);
        check_int({tag, "_pe_vld_i"}, n_vi, L);
        check_int({tag, "_ctl11"}, n_c3, (v.n_in == 1) ? L : 0);
        check_int({tag, "_done_cycle"}, done_cyc, L + 4);
        check_int({tag, "_done_count"}, n_done, 1);
        check_int({tag, "_busy_cycles"}, n_busy, L + 4);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n_busy, n_done, n_act, b1, d1;

        vecs[0] = '{4, 2, {16'd4, 16'd3, 16'd2, 16'd1},
                    {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                    {32'd0, 32'd0, 32'd70, 32'd30}};
        vecs[1] = '{1, 3, {16'd0, 16'd0, 16'd0, 16'hfffe},
                    {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'hfffc, 16'd3},
                    {32'd0, 32'hfffffff6, 32'd8, 32'hfffffffa}};
        vecs[2] = '{2, 1, {16'd0, 16'd0, 16'h8000, 16'h8000},
                    {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'h8000, 16'h8000},
                    {32'd0, 32'd0, 32'd0, 32'h80000000}};
        vecs[3] = '{3, 2, {16'd0, 16'd3, 16'hffff, 16'd2},
                    {16'd0, 16'd0, 16'd6, 16'd5, 16'hfffc, 16'd3, 16'd2, 16'd1},
                    {32'd0, 32'd0, 32'd5, 32'd9}};

        bus.start       = 1'b0;
        bus.cfg_num_in  = '0;
        bus.cfg_num_out = '0;

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int k = 0; k < 4; k++) run_vec(k, vecs[k], 1'b0);

        // Zero configuration: one cycle of busy+done, no activity at all
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.cfg_num_in  = 10'd0;
        bus.cfg_num_out = 10'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_busy = 0; n_done = 0; n_act = 0; b1 = 0; d1 = 0;
        for (int rel = 1; rel <= 6; rel++) begin
            @(negedge clk);
            if (rel == 1) begin
                b1 = int'(bus.busy);
                d1 = int'(bus.done);
            end
            n_busy += int'(bus.busy);
            n_done += int'(bus.done);
            n_act  += int'(bus.nram_rd_en) + int'(bus.wram_rd_en) + int'(bus.pe_vld_i)
                      + int'(bus.oram_we);
        end
        check_int("zero_busy_c1", b1, 1);
        check_int("zero_done_c1", d1, 1);
        check_int("zero_busy_total", n_busy, 1);
        check_int("zero_done_total", n_done, 1);
        check_int("zero_activity", n_act, 0);

        // Start pulses during RUN/DONE and cfg changes mid-run must not disturb the layer
        run_vec(0, vecs[0], 1'b1);

        // Asynchronous reset in the middle of RUN
        for (int k = 0; k < 16; k++) begin
            nmem[k] = (k < 4) ? vecs[0].nrn[k] : 16'sd0;
            wmem[k] = (k < 8) ? vecs[0].wgt[k] : 16'sd0;
        end
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.cfg_num_in  = 10'd4;
        bus.cfg_num_out = 10'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_int("pre_rst_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_quiet("mid_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // A stray PE valid in IDLE must not produce a write
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        n_act = 0; n_busy = 0;
        for (int rel = 0; rel < 4; rel++) begin
            @(negedge clk);
            n_act  += int'(bus.oram_we);
            n_busy += int'(bus.busy);
        end
        check_int("post_rst_writes", n_act, 0);
        check_int("post_rst_busy", n_busy, 0);

        run_vec(0, vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
